// File: rtl/elevator_pkg.sv
// Shared elevator constants and width derivations used by the call registry
// and the elevator controller.
package elevator_pkg;

  localparam int FLOORS_DEFAULT          = 8;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

  // Width of a floor index; a 1-bit floor for degenerate sizes keeps ports legal.
  function automatic int floor_w(input int floors);
    return (floors < 2) ? 1 : $clog2(floors);
  endfunction

  // Wide enough to hold the count of every existing call bit (3*floors-2).
  function automatic int cnt_w(input int floors);
    return $clog2(3 * floors - 1);
  endfunction

endpackage

// File: rtl/call_registry_btn_debounce.sv
// Single-button debouncer: registers the raw input once, counts consecutive
// disagreeing samples and emits a one-cycle pulse on a debounced rising edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sample;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sample  <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sample  <= raw;
      level_d <= level;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        // The DEBOUNCE_CYCLES-th consecutive differing sample flips the state.
        level <= sample;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/call_registry.sv
// Elevator call registry: latches debounced cabin/hall presses, applies
// lockout/clear/cancel priority and exports floor-relative summaries.
module call_registry
  import elevator_pkg::*;
#(
  parameter int FLOORS          = FLOORS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit CANCEL_EN       = 1'b1,
  parameter int FLOOR_W         = floor_w(FLOORS),
  parameter int CNT_W           = cnt_w(FLOORS)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [FLOORS-1:0]  btn_in,
  input  logic [FLOORS-2:0]  btn_up_out,
  input  logic [FLOORS-1:1]  btn_down_out,
  input  logic [FLOORS-1:0]  inactivate_in_levels,
  input  logic [FLOORS-2:0]  inactivate_out_up_levels,
  input  logic [FLOORS-1:1]  inactivate_out_down_levels,
  input  logic [FLOORS-1:0]  lock_levels,
  input  logic [FLOOR_W-1:0] current_floor,
  output logic [FLOORS-1:0]  active_in_levels,
  output logic [FLOORS-2:0]  active_out_up_levels,
  output logic [FLOORS-1:1]  active_out_down_levels,
  output logic               any_above,
  output logic               any_here,
  output logic               any_below,
  output logic [CNT_W-1:0]   call_count
);

  localparam int ALL_W = 3 * FLOORS - 2;

  logic [FLOORS-1:0] press_in;
  logic [FLOORS-2:0] press_up;
  logic [FLOORS-1:1] press_down;

  logic [FLOORS-1:0] in_nxt;
  logic [FLOORS-2:0] up_nxt;
  logic [FLOORS-1:1] down_nxt;

  logic [FLOORS-1:0] here_mask;
  logic [FLOORS-1:0] call_flag;
  logic [ALL_W-1:0]  all_bits;

  for (genvar g = 0; g < FLOORS; g++) begin : g_in
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (btn_in[g]),
      .press (press_in[g])
    );
  end

  for (genvar g = 0; g < FLOORS - 1; g++) begin : g_up
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (btn_up_out[g]),
      .press (press_up[g])
    );
  end

  for (genvar g = 1; g < FLOORS; g++) begin : g_down
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock (clock),
      .reset (reset),
      .raw   (btn_down_out[g]),
      .press (press_down[g])
    );
  end

  always_comb begin
    here_mask = '0;
    for (int f = 0; f < FLOORS; f++) begin
      here_mask[f] = (current_floor == FLOOR_W'(f));
    end
  end

  // Priority per bit: lockout, then clear strobe, then press (set or cancel).
  always_comb begin
    in_nxt   = active_in_levels;
    up_nxt   = active_out_up_levels;
    down_nxt = active_out_down_levels;
    for (int f = 0; f < FLOORS; f++) begin
      if (lock_levels[f] || inactivate_in_levels[f]) begin
        in_nxt[f] = 1'b0;
      end else if (press_in[f]) begin
        if (!active_in_levels[f]) begin
          in_nxt[f] = 1'b1;
        end else if (CANCEL_EN && !here_mask[f]) begin
          in_nxt[f] = 1'b0;
        end
      end
    end
    for (int f = 0; f < FLOORS - 1; f++) begin
      if (lock_levels[f] || inactivate_out_up_levels[f]) begin
        up_nxt[f] = 1'b0;
      end else if (press_up[f]) begin
        up_nxt[f] = 1'b1;
      end
    end
    for (int f = 1; f < FLOORS; f++) begin
      if (lock_levels[f] || inactivate_out_down_levels[f]) begin
        down_nxt[f] = 1'b0;
      end else if (press_down[f]) begin
        down_nxt[f] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      active_in_levels       <= '0;
      active_out_up_levels   <= '0;
      active_out_down_levels <= '0;
    end else begin
      active_in_levels       <= in_nxt;
      active_out_up_levels   <= up_nxt;
      active_out_down_levels <= down_nxt;
    end
  end

  // Hall vectors padded to full floor width; the missing edge bits read as 0.
  assign call_flag = active_in_levels
                   | {1'b0, active_out_up_levels}
                   | {active_out_down_levels, 1'b0};

  // An out-of-range floor compares greater than every index, so every call is below.
  always_comb begin
    any_above = 1'b0;
    any_here  = 1'b0;
    any_below = 1'b0;
    for (int f = 0; f < FLOORS; f++) begin
      if (FLOOR_W'(f) > current_floor) begin
        any_above = any_above | call_flag[f];
      end
      if (FLOOR_W'(f) < current_floor) begin
        any_below = any_below | call_flag[f];
      end
      any_here = any_here | (call_flag[f] & here_mask[f]);
    end
  end

  assign all_bits = {active_in_levels, active_out_up_levels, active_out_down_levels};

  always_comb begin
    call_count = '0;
    for (int i = 0; i < ALL_W; i++) begin
      call_count = call_count + CNT_W'(all_bits[i]);
    end
  end

endmodule

// File: tb/tb_call_registry.sv
// Directed bench for call_registry: stimulus pushes expected output snapshots
// with a due cycle; a negedge monitor pops and compares them.
module tb_call_registry;

  localparam int FLOORS = 8;
  localparam int W      = 30;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  btn_in = '0;
  logic [6:0]  btn_up_out = '0;
  logic [7:1]  btn_down_out = '0;
  logic [7:0]  inactivate_in_levels = '0;
  logic [6:0]  inactivate_out_up_levels = '0;
  logic [7:1]  inactivate_out_down_levels = '0;
  logic [7:0]  lock_levels = '0;
  logic [2:0]  current_floor = '0;
  logic [7:0]  active_in_levels;
  logic [6:0]  active_out_up_levels;
  logic [7:1]  active_out_down_levels;
  logic        any_above;
  logic        any_here;
  logic        any_below;
  logic [4:0]  call_count;

  call_registry #(
    .FLOORS          (FLOORS),
    .DEBOUNCE_CYCLES (4),
    .CANCEL_EN       (1'b1)
  ) dut (
    .clock                      (clock),
    .reset                      (reset),
    .btn_in                     (btn_in),
    .btn_up_out                 (btn_up_out),
    .btn_down_out               (btn_down_out),
    .inactivate_in_levels       (inactivate_in_levels),
    .inactivate_out_up_levels   (inactivate_out_up_levels),
    .inactivate_out_down_levels (inactivate_out_down_levels),
    .lock_levels                (lock_levels),
    .current_floor              (current_floor),
    .active_in_levels           (active_in_levels),
    .active_out_up_levels       (active_out_up_levels),
    .active_out_down_levels     (active_out_down_levels),
    .any_above                  (any_above),
    .any_here                   (any_here),
    .any_below                  (any_below),
    .call_count                 (call_count)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  function automatic logic [W-1:0] pk(input logic [7:0] i, input logic [6:0] u,
                                      input logic [6:0] d, input logic a,
                                      input logic h, input logic b,
                                      input logic [4:0] n);
    return {i, u, d, a, h, b, n};
  endfunction

  logic [W-1:0] actual;
  assign actual = {active_in_levels, active_out_up_levels, active_out_down_levels,
                   any_above, any_here, any_below, call_count};

  always @(negedge clock) begin
    for (int i = due_q.size() - 1; i >= 0; i--) begin
      if (due_q[i] <= cyc) begin
        checks++;
        if (due_q[i] != cyc || actual !== exp_q[i]) begin
          errors++;
          $display("FAIL %s: cycle %0d got %h expected %h (due %0d)",
                   name_q[i], cyc, actual, exp_q[i], due_q[i]);
        end
        due_q.delete(i);
        exp_q.delete(i);
        name_q.delete(i);
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_at(input int dly, input string nm, input logic [W-1:0] v);
    due_q.push_back(cyc + dly);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  logic [W-1:0] z;

  initial begin
    z = '0;
    reset = 1'b1;
    tick(2);
    expect_at(0, "reset_state", z);
    tick(1);
    reset = 1'b0;

    // Cabin call at floor 3, latency 5 edges after the first sample.
    current_floor = 3'd0;
    btn_in[3] = 1'b1;
    expect_at(5, "in3_pre", z);
    expect_at(6, "in3_set", pk(8'h08, 7'h00, 7'h00, 1, 0, 0, 5'd1));
    expect_at(9, "in3_hold", pk(8'h08, 7'h00, 7'h00, 1, 0, 0, 5'd1));
    tick(10);
    btn_in[3] = 1'b0;
    tick(8);
    inactivate_in_levels[3] = 1'b1;
    expect_at(1, "in3_clear", z);
    tick(1);
    inactivate_in_levels[3] = 1'b0;

    // Two-sample glitch on hall-up 2 is filtered.
    btn_up_out[2] = 1'b1;
    tick(2);
    btn_up_out[2] = 1'b0;
    expect_at(4, "up2_glitch", z);
    expect_at(8, "up2_glitch_late", z);
    tick(10);

    // Cabin cancel away from the current floor.
    current_floor = 3'd2;
    btn_in[5] = 1'b1;
    expect_at(6, "in5_set", pk(8'h20, 7'h00, 7'h00, 1, 0, 0, 5'd1));
    tick(7);
    btn_in[5] = 1'b0;
    tick(8);
    btn_in[5] = 1'b1;
    expect_at(5, "in5_pre_cancel", pk(8'h20, 7'h00, 7'h00, 1, 0, 0, 5'd1));
    expect_at(6, "in5_cancel", z);
    tick(7);
    btn_in[5] = 1'b0;
    tick(8);

    // Re-press at the current floor does not cancel.
    current_floor = 3'd5;
    btn_in[5] = 1'b1;
    expect_at(6, "in5_set_here", pk(8'h20, 7'h00, 7'h00, 0, 1, 0, 5'd1));
    tick(7);
    btn_in[5] = 1'b0;
    tick(8);
    btn_in[5] = 1'b1;
    expect_at(6, "in5_repress_here", pk(8'h20, 7'h00, 7'h00, 0, 1, 0, 5'd1));
    expect_at(8, "in5_repress_late", pk(8'h20, 7'h00, 7'h00, 0, 1, 0, 5'd1));
    tick(8);
    btn_in[5] = 1'b0;
    tick(8);
    inactivate_in_levels[5] = 1'b1;
    expect_at(1, "in5_clear", z);
    tick(1);
    inactivate_in_levels[5] = 1'b0;

    // Hall-down 4 alone, then cleared.
    current_floor = 3'd0;
    btn_down_out[4] = 1'b1;
    expect_at(6, "dn4_set", pk(8'h00, 7'h00, 7'h08, 1, 0, 0, 5'd1));
    tick(7);
    btn_down_out[4] = 1'b0;
    tick(8);
    inactivate_out_down_levels[4] = 1'b1;
    expect_at(1, "dn4_clear", z);
    tick(1);
    inactivate_out_down_levels[4] = 1'b0;

    // Clear strobe coincident with the press pulse wins.
    btn_down_out[4] = 1'b1;
    tick(5);
    inactivate_out_down_levels[4] = 1'b1;
    tick(1);
    inactivate_out_down_levels[4] = 1'b0;
    expect_at(0, "dn4_clear_wins", z);
    expect_at(3, "dn4_no_retrigger", z);
    tick(3);
    btn_down_out[4] = 1'b0;
    tick(8);

    // Lockout of floor 1.
    current_floor = 3'd3;
    btn_in[1] = 1'b1;
    btn_up_out[1] = 1'b1;
    btn_down_out[6] = 1'b1;
    expect_at(6, "mix_set", pk(8'h02, 7'h02, 7'h20, 1, 0, 1, 5'd3));
    tick(7);
    btn_in[1] = 1'b0;
    btn_up_out[1] = 1'b0;
    btn_down_out[6] = 1'b0;
    tick(8);
    lock_levels[1] = 1'b1;
    expect_at(1, "lock1", pk(8'h00, 7'h00, 7'h20, 1, 0, 0, 5'd1));
    tick(2);
    btn_in[1] = 1'b1;
    btn_up_out[1] = 1'b1;
    expect_at(6, "lock1_press", pk(8'h00, 7'h00, 7'h20, 1, 0, 0, 5'd1));
    expect_at(8, "lock1_press_late", pk(8'h00, 7'h00, 7'h20, 1, 0, 0, 5'd1));
    tick(8);
    btn_in[1] = 1'b0;
    btn_up_out[1] = 1'b0;
    tick(8);
    lock_levels[1] = 1'b0;
    expect_at(1, "unlock1", pk(8'h00, 7'h00, 7'h20, 1, 0, 0, 5'd1));
    tick(2);
    inactivate_out_down_levels[6] = 1'b1;
    expect_at(1, "dn6_clear", z);
    tick(1);
    inactivate_out_down_levels[6] = 1'b0;

    // Reset mid-debounce discards pending calls and the partial count.
    btn_in[2] = 1'b1;
    expect_at(6, "in2_set", pk(8'h04, 7'h00, 7'h00, 0, 0, 1, 5'd1));
    tick(7);
    btn_in[2] = 1'b0;
    tick(8);
    btn_in[0] = 1'b1;
    tick(2);
    reset = 1'b1;
    expect_at(1, "mid_reset", z);
    tick(1);
    reset = 1'b0;
    expect_at(5, "in0_pre", z);
    expect_at(6, "in0_set", pk(8'h01, 7'h00, 7'h00, 0, 0, 1, 5'd1));
    tick(8);
    btn_in[0] = 1'b0;

    for (int i = 0; i < 100 && due_q.size() > 0; i++) tick(1);
    if (due_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d checks pending, required 0", due_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/call_registry.md
Name: call_registry

Overview:
- Parametrised successor of the elevator call-button register.
- Latches debounced cabin (in), hall-up and hall-down presses for FLOORS floors.
- Clears calls on per-floor inactivate strobes; optional cabin-call cancel by re-press; per-floor service lockout.
- Exports floor-relative summaries (above/here/below) and a call count to the elevator controller FSM.

Parameters:
- FLOORS, 8, number of floors; must be >= 2.
- DEBOUNCE_CYCLES, 4, consecutive equal samples needed to change a debounced button state; must be >= 1.
- CANCEL_EN, 1, 1 = a second press on an active cabin call clears it.
- FLOOR_W, $clog2(FLOORS), width of floor index.
- CNT_W, $clog2(3*FLOORS-1), width of call_count.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- btn_in  in  FLOORS [FLOORS-1:0]  raw cabin buttons.
- btn_up_out  in  FLOORS-1 [FLOORS-2:0]  raw hall-up buttons.
- btn_down_out  in  FLOORS-1 [FLOORS-1:1]  raw hall-down buttons.
- inactivate_in_levels  in  FLOORS [FLOORS-1:0]  clear cabin call strobes.
- inactivate_out_up_levels  in  FLOORS-1 [FLOORS-2:0]  clear hall-up strobes.
- inactivate_out_down_levels  in  FLOORS-1 [FLOORS-1:1]  clear hall-down strobes.
- lock_levels  in  FLOORS  1 = floor out of service.
- current_floor  in  FLOOR_W  cabin position from the controller.
- active_in_levels  out  FLOORS [FLOORS-1:0]  registered cabin calls.
- active_out_up_levels  out  FLOORS-1 [FLOORS-2:0]  registered hall-up calls.
- active_out_down_levels  out  FLOORS-1 [FLOORS-1:1]  registered hall-down calls.
- any_above  out  1  any call at floor > current_floor.
- any_here  out  1  any call at floor == current_floor.
- any_below  out  1  any call at floor < current_floor.
- call_count  out  CNT_W  popcount of all active bits.

Behaviour:
- Reset: all active vectors 0, all debounce counters and states 0; summaries and call_count therefore 0. Reset dominates every other input. Reset asserted mid-debounce discards the partial count.
- Debounce, per button:
  - Raw input is registered once.
  - A counter counts consecutive samples differing from the debounced state.
  - When the count reaches DEBOUNCE_CYCLES the debounced state flips and the counter clears.
  - Any sample equal to the debounced state clears the counter.
- Press event: single-cycle pulse on a debounced 0->1 transition only. Holding the button never re-triggers; a new event requires a debounced release first.
- Latency: with the raw input held high from edge k, the active bit is 1 after edge k+DEBOUNCE_CYCLES+1. A glitch shorter than DEBOUNCE_CYCLES samples has no effect.
- Next-state per active bit, highest priority first:
  1. lock_levels[f] = 1 -> 0 (cleared and held clear while locked).
  2. Inactivate strobe = 1 -> 0. A clear beats a simultaneous press event.
  3. Press event and bit = 0 -> 1.
  4. Press event and bit = 1 -> 0, only for cabin bits, only when CANCEL_EN = 1 and f != current_floor.
  5. Otherwise hold.
- Hall bits ignore rule 4; a re-press keeps them 1.
- Unused edge floors: no up call at FLOORS-1, no down call at 0. These bits do not exist.
- Summaries and call_count are combinational from the active registers, so they are consistent in the same cycle.
  - For each floor, the call flag is the OR of its in/up/down bits.
  - current_floor >= FLOORS (out of range): any_here = 0, any_above = 0, any_below = OR of all bits.
- call_count range is 0..3*FLOORS-2 and never wraps.

Decomposition:
- Package elevator_pkg holds FLOORS default, DEBOUNCE_CYCLES default, and the FLOOR_W/CNT_W derivation functions, shared with the controller.
- One sub-module, btn_debounce: single-bit sample flop, counter, debounced state and press-event output. It is instantiated 3*FLOORS-2 times via generate.
- The top level holds the active registers, priority logic, summaries and popcount.

Test Plan:
- Reset then btn_in[3] held high 10 cycles, DEBOUNCE_CYCLES=4 -> active_in_levels = 8'h08 exactly 5 edges after first sample; call_count = 1; with current_floor = 0: any_above = 1, any_here = 0.
- btn_up_out[2] pulsed for 2 cycles -> no change in active_out_up_levels; call_count stays 0.
- Active cabin call on floor 5, current_floor = 2: release then re-press btn_in[5] -> bit clears, call_count decrements. Repeat with current_floor = 5 -> bit stays 1.
- Press event on btn_down_out[4] in the same cycle as inactivate_out_down_levels[4] = 1 -> bit remains 0.
- Calls on in[1], up[1], down[6]; assert lock_levels[1] -> in[1] and up[1] clear next edge, down[6] stays. New presses on floor 1 are ignored while locked.
- Calls pending, reset pulsed for 1 cycle mid-debounce of btn_in[0] -> all outputs 0 after that edge; btn_in[0] still held then needs a full DEBOUNCE_CYCLES+1 edges to register.
